// File: rtl/glay_arbiter_pkg.sv
// State encoding and sizing helpers for the kernel cache request arbiter.
package glay_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_RESET,
    ARB_IDLE,
    ARB_BURST
  } cache_arbiter_state;

  // beat_count only has to reach MAX_BURST-1, but never shrinks below one bit
  function automatic int beat_count_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/glay_req_pkg.sv
// Memory request packet shared by the kernel request producers and the cache request path.
package glay_req_pkg;

  localparam int REQ_PAYLOAD_WIDTH = 32;

  typedef struct packed {
    logic                         valid;
    logic [REQ_PAYLOAD_WIDTH-1:0] payload;
  } MemoryRequestPacket;

endpackage

// File: rtl/glay_round_robin_select.sv
// Combinational round-robin pick: first asserted request at or after rr_pointer, wrapping.
module glay_round_robin_select #(
  parameter int NUM_REQUESTORS = 2,
  parameter int INDEX_WIDTH    = 1
) (
  input  logic [NUM_REQUESTORS-1:0] request,
  input  logic [INDEX_WIDTH-1:0]    rr_pointer,
  output logic [NUM_REQUESTORS-1:0] winner_onehot,
  output logic [INDEX_WIDTH-1:0]    winner_index,
  output logic                      winner_valid
);

  logic [2*NUM_REQUESTORS-1:0] request_twice;
  logic [2*NUM_REQUESTORS-1:0] request_shifted;
  logic [NUM_REQUESTORS-1:0]   request_rotated;
  logic [INDEX_WIDTH:0]        index_sum;

  // Rotating a doubled vector puts rr_pointer at bit 0 so a plain priority scan works
  assign request_twice   = {request, request};
  assign request_shifted = request_twice >> rr_pointer;
  assign request_rotated = request_shifted[NUM_REQUESTORS-1:0];

  always_comb begin
    winner_valid  = 1'b0;
    winner_index  = '0;
    winner_onehot = '0;
    index_sum     = '0;
    for (int j = NUM_REQUESTORS - 1; j >= 0; j--) begin
      if (request_rotated[j]) begin
        winner_valid = 1'b1;
        index_sum    = {1'b0, rr_pointer} + (INDEX_WIDTH+1)'(j);
      end
    end
    // Compare-and-subtract wrap keeps non-power-of-two counts correct
    if (index_sum >= (INDEX_WIDTH+1)'(NUM_REQUESTORS)) begin
      index_sum = index_sum - (INDEX_WIDTH+1)'(NUM_REQUESTORS);
    end
    winner_index = index_sum[INDEX_WIDTH-1:0];
    if (winner_valid) begin
      winner_onehot = NUM_REQUESTORS'(1) << winner_index;
    end
  end

endmodule

// File: rtl/glay_kernel_cache_arbiter.sv
// Round-robin burst arbiter feeding the kernel cache request FIFO through a registered output.
// Optional per-requester beat counters are built when GLAY_CACHE_ARBITER_STATS_EN is defined.
module glay_kernel_cache_arbiter
  import glay_req_pkg::*, glay_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTORS = 2,
  parameter int MAX_BURST      = 8,
  parameter int COUNTER_WIDTH  = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      arbiter_enable,
  input  MemoryRequestPacket        req_in [NUM_REQUESTORS],
  output logic [NUM_REQUESTORS-1:0] req_in_ready,
  input  logic                      req_out_fifo_almost_full,
  output MemoryRequestPacket        req_out,
  output logic [NUM_REQUESTORS-1:0] grant_onehot,
  output logic                      arbiter_busy
`ifdef GLAY_CACHE_ARBITER_STATS_EN
  ,
  output logic [COUNTER_WIDTH-1:0]  grant_count [NUM_REQUESTORS]
`endif
);

  localparam int                IDX_W      = $clog2(NUM_REQUESTORS);
  localparam int                BEAT_W     = beat_count_width(MAX_BURST);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_INDEX = IDX_W'(NUM_REQUESTORS - 1);

  cache_arbiter_state        state_reg, state_next;
  logic [NUM_REQUESTORS-1:0] grant_onehot_reg, grant_onehot_next;
  logic [IDX_W-1:0]          grant_index_reg, grant_index_next;
  logic [IDX_W-1:0]          rr_pointer_reg, rr_pointer_next;
  logic [BEAT_W-1:0]         beat_count_reg, beat_count_next;
  MemoryRequestPacket        req_out_reg, req_out_next;

  logic [NUM_REQUESTORS-1:0] req_valid;
  logic [NUM_REQUESTORS-1:0] winner_onehot;
  logic [IDX_W-1:0]          winner_index;
  logic                      winner_valid;
  logic                      forward_open;
  logic                      granted_valid;
  logic                      transfer;

  generate
    for (genvar gi = 0; gi < NUM_REQUESTORS; gi++) begin : g_req
      assign req_valid[gi]    = req_in[gi].valid;
      assign req_in_ready[gi] = forward_open & grant_onehot_reg[gi];
    end
  endgenerate

  assign forward_open  = (state_reg == ARB_BURST) && !req_out_fifo_almost_full && arbiter_enable;
  assign granted_valid = req_valid[grant_index_reg];
  assign transfer      = forward_open && granted_valid;

  glay_round_robin_select #(
    .NUM_REQUESTORS (NUM_REQUESTORS),
    .INDEX_WIDTH    (IDX_W)
  ) u_select (
    .request       (req_valid),
    .rr_pointer    (rr_pointer_reg),
    .winner_onehot (winner_onehot),
    .winner_index  (winner_index),
    .winner_valid  (winner_valid)
  );

  always_comb begin
    state_next           = state_reg;
    grant_onehot_next    = grant_onehot_reg;
    grant_index_next     = grant_index_reg;
    rr_pointer_next      = rr_pointer_reg;
    beat_count_next      = beat_count_reg;
    req_out_next.valid   = transfer;
    req_out_next.payload = transfer ? req_in[grant_index_reg].payload : req_out_reg.payload;
    case (state_reg)
      ARB_RESET: state_next = ARB_IDLE;
      ARB_IDLE: begin
        if (arbiter_enable && winner_valid) begin
          state_next        = ARB_BURST;
          grant_onehot_next = winner_onehot;
          grant_index_next  = winner_index;
          beat_count_next   = '0;
        end
      end
      ARB_BURST: begin
        if (transfer) begin
          beat_count_next = beat_count_reg + 1'b1;
        end
        // almost_full alone only stalls; the grant ends on a drop, the burst limit or disable
        if (!granted_valid || !arbiter_enable || (transfer && beat_count_reg == LAST_BEAT)) begin
          state_next        = ARB_IDLE;
          grant_onehot_next = '0;
          rr_pointer_next   = (grant_index_reg == LAST_INDEX) ? '0 : grant_index_reg + 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg        <= ARB_RESET;
      grant_onehot_reg <= '0;
      grant_index_reg  <= '0;
      rr_pointer_reg   <= '0;
      beat_count_reg   <= '0;
      req_out_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      grant_onehot_reg <= grant_onehot_next;
      grant_index_reg  <= grant_index_next;
      rr_pointer_reg   <= rr_pointer_next;
      beat_count_reg   <= beat_count_next;
      req_out_reg      <= req_out_next;
    end
  end

  assign req_out      = req_out_reg;
  assign grant_onehot = grant_onehot_reg;
  assign arbiter_busy = (state_reg == ARB_BURST);

`ifdef GLAY_CACHE_ARBITER_STATS_EN
  logic [COUNTER_WIDTH-1:0] grant_count_reg [NUM_REQUESTORS];

  generate
    for (genvar gi = 0; gi < NUM_REQUESTORS; gi++) begin : g_stats
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          grant_count_reg[gi] <= '0;
        end else if (req_in_ready[gi] && req_valid[gi] && (grant_count_reg[gi] != '1)) begin
          grant_count_reg[gi] <= grant_count_reg[gi] + 1'b1;
        end
      end
      assign grant_count[gi] = grant_count_reg[gi];
    end
  endgenerate
`else
  // statistics counters are not built in this configuration
`endif

endmodule

// File: doc/glay_kernel_cache_arbiter.md
# glay_kernel_cache_arbiter

Round-robin arbiter that shares the single kernel cache request FIFO between several request producers: the setup path, serial read engines and later graph engines. Each requester presents a MemoryRequestPacket stream. The arbiter grants one requester at a time for a bounded burst and forwards its beats through a registered output into the downstream request FIFO, respecting that FIFO's almost_full. It sits in the kernel between the engine request FIFOs and the cache request-out FIFO.

## Interface
Parameters:
- NUM_REQUESTORS, 2 — number of request producers; legal range 2–16.
- MAX_BURST, 8 — maximum beats forwarded per grant; legal range 1–256.
- COUNTER_WIDTH, 32 — width of the statistics counters.

Ports:
- ap_clk  in  1  — single kernel clock; all logic on its rising edge.
- ap_rst_n  in  1  — asynchronous, active-low reset.
- arbiter_enable  in  1  — from the kernel control state; 0 blocks new grants.
- req_in  in  NUM_REQUESTORS x MemoryRequestPacket — per-requester valid + payload.
- req_in_ready  out  NUM_REQUESTORS — per-requester accept.
- req_out_fifo_almost_full  in  1 — almost_full of the downstream request FIFO.
- req_out  out  MemoryRequestPacket — forwarded beat, registered.
- grant_onehot  out  NUM_REQUESTORS — current grant, registered.
- arbiter_busy  out  1 — 1 while a grant is active.
- grant_count  out  NUM_REQUESTORS x COUNTER_WIDTH — beats forwarded per requester. Present only with GLAY_CACHE_ARBITER_STATS_EN.

## Operation
- Reset values, forced asynchronously while ap_rst_n=0:
  - req_out.valid=0, req_out.payload=0.
  - grant_onehot=0, arbiter_busy=0.
  - rr_pointer=0, beat_count=0, grant_count=0.
  - state=ARB_RESET.
- A beat transfers on requester i when req_in[i].valid && req_in_ready[i] are both 1.
- req_in_ready[i] = (state==ARB_BURST) && grant_onehot[i] && !req_out_fifo_almost_full && arbiter_enable. This is combinational from registered state and the two inputs.
- State machine:
  - ARB_RESET -> ARB_IDLE, unconditionally, on the first cycle after reset release.
  - ARB_IDLE:
    - If arbiter_enable and any req_in.valid: pick the first valid requester at index >= rr_pointer, wrapping modulo NUM_REQUESTORS.
    - Load grant_onehot with that requester, clear beat_count, go to ARB_BURST.
    - Otherwise stay in ARB_IDLE.
  - ARB_BURST: each transfer increments beat_count. Go to ARB_IDLE on the first cycle in which any of these holds:
    - the granted requester's valid=0;
    - a transfer occurs with beat_count==MAX_BURST-1;
    - arbiter_enable=0.
  - On leaving ARB_BURST: rr_pointer = granted index + 1 (wraps at NUM_REQUESTORS), and grant_onehot clears.
- Backpressure: req_out_fifo_almost_full=1 stalls the burst without ending it. beat_count holds and the grant is kept.
- arbiter_busy = (state==ARB_BURST).
- Payload pass-through is unmodified; no reordering within a requester.
- Simultaneous valids: only the round-robin winner is served. The others wait with ready=0, and their valid must stay asserted with payload stable.
- With NUM_REQUESTORS not a power of two, pointer wrap is explicit compare-and-clear, not truncation.

## Timing
- Arbitration: 1 cycle (ARB_IDLE) between a valid request and the first ready.
- Throughput: 1 beat/cycle inside a burst. There is exactly 1 idle cycle between consecutive bursts.
- Latency: req_in transfer at cycle t -> req_out.valid=1 with the same payload at t+1. req_out.valid is 0 in any cycle without a transfer in the previous cycle.
- Downstream FIFO: almost_full must assert with at least 2 free entries, covering the 1-cycle output register.
- Starvation bound: a continuously valid requester is granted within (NUM_REQUESTORS-1)*(MAX_BURST+1)+1 cycles, provided almost_full is deasserted and arbiter_enable=1.
- Reset mid-burst: the in-flight req_out beat is dropped (valid cleared asynchronously), and arbitration restarts from requester 0.

## Configuration
- GLAY_CACHE_ARBITER_STATS_EN defined:
  - Per-requester saturating COUNTER_WIDTH counters increment on each transfer and drive grant_count.
  - Counters clear on reset only, and saturate at all-ones.
- Undefined: the grant_count port and the counters are absent.

## Structure
- Shared package GLAY_ARBITER_PKG holds:
  - the cache_arbiter_state enum (ARB_RESET, ARB_IDLE, ARB_BURST);
  - the MAX_BURST width localparam helper.
- MemoryRequestPacket stays in GLAY_REQ_PKG.
- One sub-module, glay_round_robin_select: combinational masked priority encoder. Inputs are the request vector and rr_pointer; outputs are the one-hot winner and its index.

## Test plan
- Single requester: req 0 sends 3 beats with payload 0xA0–0xA2. Expected: ready at cycle 1; req_out carries A0, A1, A2 at cycles 2–4; then ARB_IDLE; rr_pointer=1.
- Two requesters, both continuously valid, MAX_BURST=8. Expected: grants alternate 0,1,0 with 8 beats each and one idle cycle between bursts; no beat lost.
- almost_full raised for 5 cycles mid-burst after beat 3. Expected: ready=0 for those 5 cycles, grant held, beat_count=3 held; the burst resumes and ends after 8 total beats.
- arbiter_enable dropped in beat 2 of a burst. Expected: ready=0 that cycle, ARB_IDLE next cycle; no further grant until enable returns.
- ap_rst_n asserted mid-burst. Expected: req_out.valid=0, grant_onehot=0 immediately; after release, requester 0 is granted first even if rr_pointer was 1.
- With GLAY_CACHE_ARBITER_STATS_EN, 20 beats from req 0 and 7 from req 1. Expected: grant_count = {7, 20}.
